// File: rtl/button_press_decoder_if.sv
// ---------------------------------------------------------------------------
// button_press_decoder_if
//
// Purpose:
//   Bundles the raw button input and the decoded button events that pass
//   between the board button pad and the user control logic.
//
// Signals:
//   BTN_N          raw button, active-low, asynchronous to the system clock
//   pressed        debounced level, 1 = held
//   press_pulse    1-cycle strobe on an accepted press
//   release_pulse  1-cycle strobe on an accepted release
//   short_press    1-cycle strobe at release when no long_press fired
//   long_press     1-cycle strobe when the hold reaches the long threshold
//   hold_cycles    hold duration of the current/last press, saturating
//
// Modports:
//   master  pad / user side: drives BTN_N, consumes the decoded events
//   slave   the decoder: samples BTN_N, produces the decoded events
// ---------------------------------------------------------------------------
interface button_press_decoder_if #(
  parameter int HOLD_W = 24
);

  logic              BTN_N;
  logic              pressed;
  logic              press_pulse;
  logic              release_pulse;
  logic              short_press;
  logic              long_press;
  logic [HOLD_W-1:0] hold_cycles;

  modport master (
    output BTN_N,
    input  pressed,
    input  press_pulse,
    input  release_pulse,
    input  short_press,
    input  long_press,
    input  hold_cycles
  );

  modport slave (
    input  BTN_N,
    output pressed,
    output press_pulse,
    output release_pulse,
    output short_press,
    output long_press,
    output hold_cycles
  );

endinterface

// File: rtl/button_press_decoder.sv
// ---------------------------------------------------------------------------
// button_press_decoder
//
// Purpose:
//   Turns a raw, bouncy, active-low board button into clean events for user
//   logic. The pad is synchronised with a two-flop chain, debounced by a
//   four-state FSM, and each accepted press is timed so it can be classified
//   as short or long and its hold duration reported.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept an edge (>=1)
//   LONG_CYCLES      hold length that counts as a long press (>=1, < 2**HOLD_W)
//   HOLD_W           width of the hold-duration counter
//
// Ports:
//   CLK     system clock
//   RST_N   synchronous, active-low reset
//   btn_if  slave side of button_press_decoder_if (BTN_N in, events out);
//           its HOLD_W must match this module's HOLD_W
//
// Timing:
//   A press first sampled at edge E and held produces press_pulse in the
//   cycle after edge E+DEBOUNCE_CYCLES+2 (two synchroniser edges, one edge to
//   leave IDLE, then DEBOUNCE_CYCLES debounce edges). Release is symmetric.
//   All outputs are registered; every strobe lasts exactly one cycle.
// ---------------------------------------------------------------------------
module button_press_decoder #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int HOLD_W          = 24
) (
  input logic                   CLK,
  input logic                   RST_N,
  button_press_decoder_if.slave btn_if
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1; keep at least
  // one bit so DEBOUNCE_CYCLES=1 still elaborates.
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = {HOLD_W{1'b1}};
  localparam logic [HOLD_W-1:0] LONG_VAL = HOLD_W'(LONG_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB_PRESS,
    S_HELD,
    S_DEB_RELEASE
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic              sync1_q, sync2_q;
  state_e            state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_fired_q, long_fired_d;
  logic              pressed_q, pressed_d;
  logic              press_pulse_q, press_pulse_d;
  logic              release_pulse_q, release_pulse_d;
  logic              short_q, short_d;
  logic              long_q, long_d;

  // Synchronised button, active-high. Nothing downstream touches BTN_N.
  logic btn;
  assign btn = ~sync2_q;

  // Set on every edge that should advance the hold timer.
  logic hold_inc;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: reset is sampled on the clock edge (synchronous) and every register
  // here uses non-blocking assignment so all flops update from the same
  // pre-edge values; blocking assignment would chain sync1 straight into sync2.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      // Synchroniser resets to "released" so a button held through reset is
      // seen as a brand-new press and must debounce again.
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      state_q         <= S_IDLE;
      deb_cnt_q       <= '0;
      hold_q          <= '0;
      long_fired_q    <= 1'b0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      short_q         <= 1'b0;
      long_q          <= 1'b0;
    end else begin
      sync1_q         <= btn_if.BTN_N;
      sync2_q         <= sync1_q;
      state_q         <= state_d;
      deb_cnt_q       <= deb_cnt_d;
      hold_q          <= hold_d;
      long_fired_q    <= long_fired_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      short_q         <= short_d;
      long_q          <= long_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  // NOTE: every variable written below gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    deb_cnt_d       = deb_cnt_q;
    hold_d          = hold_q;
    long_fired_d    = long_fired_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    short_d         = 1'b0;
    long_d          = 1'b0;
    hold_inc        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (btn) begin
          state_d   = S_DEB_PRESS;
          deb_cnt_d = '0;
        end
      end

      S_DEB_PRESS: begin
        if (!btn) begin
          // Bounce: drop back silently.
          state_d = S_IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d       = S_HELD;
          pressed_d     = 1'b1;
          press_pulse_d = 1'b1;
          hold_d        = '0;
          long_fired_d  = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      S_HELD: begin
        hold_inc = 1'b1;
        if (!btn) begin
          state_d   = S_DEB_RELEASE;
          deb_cnt_d = '0;
        end
      end

      S_DEB_RELEASE: begin
        if (btn) begin
          // Release bounce: still held, keep timing, no event.
          state_d  = S_HELD;
          hold_inc = 1'b1;
        end else if (deb_cnt_q == DEB_LAST) begin
          // Release accepted; this edge does not extend the hold time.
          state_d         = S_IDLE;
          pressed_d       = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
          hold_inc  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Hold timer saturates instead of wrapping, so reaching LONG_VAL can
    // only happen once per press; long_fired guards it regardless.
    if (hold_inc && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
      if ((hold_d == LONG_VAL) && !long_fired_q) begin
        long_d       = 1'b1;
        long_fired_d = 1'b1;
      end
    end

    // Uses the post-update flag so a long press on the same edge as the
    // release still suppresses short_press.
    if (release_pulse_d) begin
      short_d = ~long_fired_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign btn_if.pressed       = pressed_q;
  assign btn_if.press_pulse   = press_pulse_q;
  assign btn_if.release_pulse = release_pulse_q;
  assign btn_if.short_press   = short_q;
  assign btn_if.long_press    = long_q;
  assign btn_if.hold_cycles   = hold_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// ---------------------------------------------------------------------------
// tb_button_press_decoder
//
// Two decoders (HOLD_W=8 and HOLD_W=5, both D=4, L=20) share one button and
// reset. A run-length model predicts every output each cycle; directed
// scenarios add hand-computed pulse counts, latencies and hold values.
// ---------------------------------------------------------------------------
module tb_button_press_decoder;

  localparam int D = 4;
  localparam int L = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn_n = 1'b1;

  always #5 clk = ~clk;

  button_press_decoder_if #(.HOLD_W(8)) bif8 ();
  button_press_decoder_if #(.HOLD_W(5)) bif5 ();

  assign bif8.BTN_N = btn_n;
  assign bif5.BTN_N = btn_n;

  button_press_decoder #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .HOLD_W          (8)
  ) dut8 (
    .CLK    (clk),
    .RST_N  (rst_n),
    .btn_if (bif8)
  );

  button_press_decoder #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .HOLD_W          (5)
  ) dut5 (
    .CLK    (clk),
    .RST_N  (rst_n),
    .btn_if (bif5)
  );

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // -------------------------------------------------------------------------
  // Model: the synchronised button is BTN_N seen two edges earlier, forced
  // to "released" while reset is in that window. The debounced level flips
  // once the button has disagreed with it for D+1 consecutive edges. Hold
  // time counts every edge spent at level 1 except the edge that releases.
  // -------------------------------------------------------------------------
  bit m_level [2];
  int m_run   [2];
  int m_hold  [2];
  bit m_fired [2];
  bit m_pp    [2];
  bit m_rp    [2];
  bit m_sp    [2];
  bit m_lp    [2];
  int m_max   [2] = '{255, 31};

  bit h_rst1 = 1'b1, h_rst2 = 1'b1;
  bit h_bn1  = 1'b1, h_bn2  = 1'b1;

  always @(posedge clk) begin
    bit b;
    cyc++;
    b = !(h_rst1 || h_rst2) && !h_bn2;
    for (int i = 0; i < 2; i++) begin
      m_pp[i] = 1'b0;
      m_rp[i] = 1'b0;
      m_sp[i] = 1'b0;
      m_lp[i] = 1'b0;
      if (!rst_n) begin
        m_level[i] = 1'b0;
        m_run[i]   = 0;
        m_hold[i]  = 0;
        m_fired[i] = 1'b0;
      end else begin
        if (b != m_level[i]) m_run[i]++;
        else                 m_run[i] = 0;
        if (m_level[i] && (m_run[i] != D + 1) && (m_hold[i] < m_max[i])) begin
          m_hold[i]++;
          if ((m_hold[i] == L) && !m_fired[i]) begin
            m_lp[i]    = 1'b1;
            m_fired[i] = 1'b1;
          end
        end
        if (m_run[i] == D + 1) begin
          m_run[i] = 0;
          if (!m_level[i]) begin
            m_level[i] = 1'b1;
            m_pp[i]    = 1'b1;
            m_hold[i]  = 0;
            m_fired[i] = 1'b0;
          end else begin
            m_level[i] = 1'b0;
            m_rp[i]    = 1'b1;
            m_sp[i]    = !m_fired[i];
          end
        end
      end
    end
    h_rst2 = h_rst1;
    h_rst1 = !rst_n;
    h_bn2  = h_bn1;
    h_bn1  = btn_n;
  end

  // -------------------------------------------------------------------------
  // Compare process and event counters (sampled mid-cycle)
  // -------------------------------------------------------------------------
  int n_press, n_rel, n_short, n_long, n_pressed_cyc;
  int n_rel5, n_short5, n_long5;
  int press_cyc, rel_cyc, short_cyc, long_cyc;

  task automatic check_out(input string tag, input int i,
                           input logic pr, input logic pp, input logic rp,
                           input logic sp, input logic lp, input logic [31:0] hc);
    check({tag, " pressed"},       32'(pr), 32'(m_level[i]));
    check({tag, " press_pulse"},   32'(pp), 32'(m_pp[i]));
    check({tag, " release_pulse"}, 32'(rp), 32'(m_rp[i]));
    check({tag, " short_press"},   32'(sp), 32'(m_sp[i]));
    check({tag, " long_press"},    32'(lp), 32'(m_lp[i]));
    check({tag, " hold_cycles"},   hc,      32'(m_hold[i]));
  endtask

  always @(negedge clk) begin
    check_out("w8", 0, bif8.pressed, bif8.press_pulse, bif8.release_pulse,
              bif8.short_press, bif8.long_press, 32'(bif8.hold_cycles));
    check_out("w5", 1, bif5.pressed, bif5.press_pulse, bif5.release_pulse,
              bif5.short_press, bif5.long_press, 32'(bif5.hold_cycles));
    if (bif8.press_pulse === 1'b1)   begin n_press++; press_cyc = cyc; end
    if (bif8.release_pulse === 1'b1) begin n_rel++;   rel_cyc   = cyc; end
    if (bif8.short_press === 1'b1)   begin n_short++; short_cyc = cyc; end
    if (bif8.long_press === 1'b1)    begin n_long++;  long_cyc  = cyc; end
    if (bif8.pressed === 1'b1)       n_pressed_cyc++;
    if (bif5.release_pulse === 1'b1) n_rel5++;
    if (bif5.short_press === 1'b1)   n_short5++;
    if (bif5.long_press === 1'b1)    n_long5++;
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // -------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_pressed_cyc = 0;
    n_rel5 = 0; n_short5 = 0; n_long5 = 0;
    press_cyc = -1; rel_cyc = -1; short_cyc = -1; long_cyc = -1;
  endtask

  // Button low for exactly n rising-edge samples; e = first low edge.
  task automatic press_for(input int n, output int e);
    @(negedge clk);
    btn_n = 1'b0;
    e     = cyc + 1;
    repeat (n) @(negedge clk);
    btn_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  // Directed scenarios
  // -------------------------------------------------------------------------
  initial begin
    int e, r;
    clear_counts();
    rst_n = 1'b0;
    btn_n = 1'b1;
    idle(3);
    check("reset pressed",     32'(bif8.pressed),     0);
    check("reset press_pulse", 32'(bif8.press_pulse), 0);
    check("reset hold",        32'(bif8.hold_cycles), 0);
    rst_n = 1'b1;
    idle(5);

    // Glitch: 3 low samples never reach the debounce threshold.
    clear_counts();
    press_for(3, e);
    idle(15);
    check("glitch press count",  32'(n_press),          0);
    check("glitch pressed cyc",  32'(n_pressed_cyc),    0);
    check("glitch release",      32'(n_rel),            0);
    check("glitch hold",         32'(bif8.hold_cycles), 0);

    // Short press, 15 samples.
    clear_counts();
    press_for(15, e);
    idle(15);
    check("p15 press count",     32'(n_press),          1);
    check("p15 press latency",   32'(press_cyc - e),    6);
    check("p15 release count",   32'(n_rel),            1);
    check("p15 release latency", 32'(rel_cyc - (e + 15)), 6);
    check("p15 short count",     32'(n_short),          1);
    check("p15 short at release", 32'(short_cyc),       32'(rel_cyc));
    check("p15 long count",      32'(n_long),           0);
    check("p15 hold",            32'(bif8.hold_cycles), 14);

    // Boundary just below the long threshold.
    clear_counts();
    press_for(20, e);
    idle(15);
    check("p20 hold",            32'(bif8.hold_cycles), 19);
    check("p20 short count",     32'(n_short),          1);
    check("p20 long count",      32'(n_long),           0);

    // Boundary exactly reaching the long threshold.
    clear_counts();
    press_for(21, e);
    idle(15);
    check("p21 hold",            32'(bif8.hold_cycles), 20);
    check("p21 long count",      32'(n_long),           1);
    check("p21 short count",     32'(n_short),          0);
    check("p21 release count",   32'(n_rel),            1);
    check("p21 long before rel", 32'(rel_cyc - long_cyc), 1);

    // Release bounce: 10 low, 2 high, 10 low, then release.
    clear_counts();
    @(negedge clk);
    btn_n = 1'b0;
    repeat (10) @(negedge clk);
    btn_n = 1'b1;
    repeat (2) @(negedge clk);
    btn_n = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce no release",   32'(n_rel),            0);
    check("bounce still held",   32'(bif8.pressed),     1);
    btn_n = 1'b1;
    idle(15);
    check("bounce press count",  32'(n_press),          1);
    check("bounce release count", 32'(n_rel),           1);
    check("bounce hold",         32'(bif8.hold_cycles), 21);
    check("bounce long count",   32'(n_long),           1);
    check("bounce short count",  32'(n_short),          0);

    // Reset while the button is held.
    clear_counts();
    @(negedge clk);
    btn_n = 1'b0;
    repeat (12) @(negedge clk);
    check("rst pre press count", 32'(n_press),          1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst pressed",         32'(bif8.pressed),     0);
    check("rst hold",            32'(bif8.hold_cycles), 0);
    check("rst no release",      32'(n_rel),            0);
    rst_n = 1'b1;
    r     = cyc + 1;
    repeat (15) @(negedge clk);
    check("rst re-press count",  32'(n_press),          2);
    check("rst re-press latency", 32'(press_cyc - r),   6);
    check("rst still no release", 32'(n_rel),           0);
    btn_n = 1'b1;
    idle(15);
    check("rst release count",   32'(n_rel),            1);
    check("rst hold after",      32'(bif8.hold_cycles), 14);

    // Saturation on the narrow counter.
    clear_counts();
    press_for(100, e);
    idle(15);
    check("sat w5 hold",         32'(bif5.hold_cycles), 31);
    check("sat w5 long count",   32'(n_long5),          1);
    check("sat w5 short count",  32'(n_short5),         0);
    check("sat w5 release count", 32'(n_rel5),          1);
    check("sat w8 hold",         32'(bif8.hold_cycles), 99);
    check("sat w8 long count",   32'(n_long),           1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
